// File: rtl/prefetch_dma_responder.sv
// prefetch_dma_responder
//   Accepts single prefetch requests from a stream prefetcher whenever the
//   cache miss unit does not own the memory port. Each request is issued as
//   one memory read, the response is captured, and the data is returned to
//   the prefetcher with a one-cycle valid pulse.
//
//   Optional feature macro: PREFETCH_DMA_TIMEOUT_EN
//     defined   -> WAIT_RESP is bounded by timeout_p cycles. On expiry the
//                  request is dropped and prefetch_drop_o pulses.
//     undefined -> WAIT_RESP waits indefinitely and prefetch_drop_o is 0.
//
// Ports
//   clk_i, reset_i             clock, synchronous active-low reset
//   prefetch_dma_req_i/addr_i  prefetch request and its address
//   demand_busy_i              miss unit owns the memory port
//   dma_busy_o                 a request presented this cycle is not taken
//   mem_req_v_o/addr_o/ready_i memory read request channel
//   mem_resp_v_i/data_i/ready_o memory response channel
//   dma_prefetch_data_o/_v_o   returned data with a one-cycle valid pulse
//   prefetch_drop_o            one-cycle pulse on a timeout abort
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no request in flight, accepting when not busy
// SEND      | memory read request presented, waiting for ready
// WAIT_RESP | request issued, waiting for the memory response
// DELIVER   | returning captured data to the prefetcher

module prefetch_dma_responder #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int timeout_p    = 255
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    prefetch_dma_req_i,
  input  logic [addr_width_p-1:0] prefetch_dma_addr_i,
  input  logic                    demand_busy_i,
  output logic                    dma_busy_o,
  output logic                    mem_req_v_o,
  output logic [addr_width_p-1:0] mem_req_addr_o,
  input  logic                    mem_req_ready_i,
  input  logic                    mem_resp_v_i,
  input  logic [data_width_p-1:0] mem_resp_data_i,
  output logic                    mem_resp_ready_o,
  output logic [data_width_p-1:0] dma_prefetch_data_o,
  output logic                    dma_prefetch_data_v_o,
  output logic                    prefetch_drop_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] DELIVER   = 2'd3;

  if (timeout_p < 1 || timeout_p > 65535) begin : g_bad_timeout
    $error("prefetch_dma_responder: timeout_p out of range 1..65535");
  end

  logic [1:0]              state_q, state_d;
  logic [addr_width_p-1:0] addr_q;
  logic [data_width_p-1:0] data_q;
  logic                    accept;
  logic                    timeout_hit;

  assign accept = (state_q == IDLE) && prefetch_dma_req_i && !demand_busy_i;

`ifdef PREFETCH_DMA_TIMEOUT_EN
  localparam logic [15:0] timeout_last_lp = 16'(timeout_p - 1);

  logic [15:0] cnt_q;
  logic        drop_q;

  // cnt_q counts the response-less WAIT_RESP cycles already elapsed, so the
  // cycle that sees timeout_last_lp is the timeout_p-th one.
  assign timeout_hit = (state_q == WAIT_RESP) && !mem_resp_v_i &&
                       (cnt_q == timeout_last_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= timeout_hit;
      if (state_q != WAIT_RESP) begin
        cnt_q <= '0;
      end else if (!mem_resp_v_i) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign prefetch_drop_o = reset_i && drop_q;
`else
  assign timeout_hit     = 1'b0;
  assign prefetch_drop_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = SEND;
      SEND:      if (mem_req_ready_i) state_d = WAIT_RESP;
      WAIT_RESP: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (mem_resp_v_i)     state_d = DELIVER;
        else if (timeout_hit) state_d = IDLE;
      end
      DELIVER:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_q <= prefetch_dma_addr_i;
      if (state_q == WAIT_RESP && mem_resp_v_i) data_q <= mem_resp_data_i;
    end
  end

  // Outputs are gated with reset_i so they read 0 during reset even before
  // the first reset edge has cleared the state.
  assign dma_busy_o            = demand_busy_i || (reset_i && state_q != IDLE);
  assign mem_req_v_o           = reset_i && (state_q == SEND);
  assign mem_req_addr_o        = reset_i ? addr_q : '0;
  assign mem_resp_ready_o      = reset_i && (state_q == WAIT_RESP);
  assign dma_prefetch_data_v_o = reset_i && (state_q == DELIVER);
  assign dma_prefetch_data_o   = reset_i ? data_q : '0;

endmodule

// File: tb/tb_prefetch_dma_responder.sv
// tb_prefetch_dma_responder
//   Transaction-level bench for prefetch_dma_responder. Each prefetch is
//   described by an address, data and the number of stall cycles on the
//   request and response channels; the expected channel activity for every
//   cycle follows from those numbers. Noise (ignored requests, stray
//   responses, demand toggling) is injected where it must have no effect.

module tb_prefetch_dma_responder;

`ifdef PREFETCH_DMA_TIMEOUT_EN
  localparam int timeout_lp  = 4;
  localparam int max_pdly_lp = timeout_lp - 1;
`else
  localparam int timeout_lp  = 255;
  localparam int max_pdly_lp = 8;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        prefetch_dma_req_i;
  logic [31:0] prefetch_dma_addr_i;
  logic        demand_busy_i;
  logic        dma_busy_o;
  logic        mem_req_v_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_resp_v_i;
  logic [31:0] mem_resp_data_i;
  logic        mem_resp_ready_o;
  logic [31:0] dma_prefetch_data_o;
  logic        dma_prefetch_data_v_o;
  logic        prefetch_drop_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_data;

  always #5 clk_i = ~clk_i;

  prefetch_dma_responder #(
    .addr_width_p(32),
    .data_width_p(32),
    .timeout_p   (timeout_lp)
  ) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .prefetch_dma_req_i   (prefetch_dma_req_i),
    .prefetch_dma_addr_i  (prefetch_dma_addr_i),
    .demand_busy_i        (demand_busy_i),
    .dma_busy_o           (dma_busy_o),
    .mem_req_v_o          (mem_req_v_o),
    .mem_req_addr_o       (mem_req_addr_o),
    .mem_req_ready_i      (mem_req_ready_i),
    .mem_resp_v_i         (mem_resp_v_i),
    .mem_resp_data_i      (mem_resp_data_i),
    .mem_resp_ready_o     (mem_resp_ready_o),
    .dma_prefetch_data_o  (dma_prefetch_data_o),
    .dma_prefetch_data_v_o(dma_prefetch_data_v_o),
    .prefetch_drop_o      (prefetch_drop_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    prefetch_dma_req_i = 1'b0;
    demand_busy_i      = 1'b0;
    mem_req_ready_i    = 1'b0;
    mem_resp_v_i       = 1'b0;
  endtask

  // One full prefetch: rdly cycles of ready low, pdly cycles without a
  // response, then delivery and one idle cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d,
                         input int rdly, input int pdly, input bit noise);
    logic dem;
    idle_inputs();
    prefetch_dma_req_i  = 1'b1;
    prefetch_dma_addr_i = a;
    #1;
    check_eq("idle_busy", dma_busy_o, 0);
    check_eq("idle_reqv", mem_req_v_o, 0);
    step();
    for (int i = 0; i <= rdly; i++) begin
      prefetch_dma_req_i  = noise;
      prefetch_dma_addr_i = 32'h3000;
      demand_busy_i       = 1'($urandom_range(0, 1));
      mem_req_ready_i     = (i == rdly);
      mem_resp_v_i        = 1'($urandom_range(0, 1));
      mem_resp_data_i     = $urandom;
      #1;
      check_eq("send_reqv", mem_req_v_o, 1);
      check_eq("send_addr", mem_req_addr_o, a);
      check_eq("send_busy", dma_busy_o, 1);
      check_eq("send_rready", mem_resp_ready_o, 0);
      check_eq("send_datav", dma_prefetch_data_v_o, 0);
      check_eq("send_hold", dma_prefetch_data_o, last_data);
      check_eq("send_drop", prefetch_drop_o, 0);
      step();
    end
    for (int i = 0; i <= pdly; i++) begin
      prefetch_dma_req_i = noise;
      demand_busy_i      = 1'($urandom_range(0, 1));
      mem_req_ready_i    = 1'($urandom_range(0, 1));
      mem_resp_v_i       = (i == pdly);
      mem_resp_data_i    = (i == pdly) ? d : $urandom;
      #1;
      check_eq("wait_rready", mem_resp_ready_o, 1);
      check_eq("wait_reqv", mem_req_v_o, 0);
      check_eq("wait_datav", dma_prefetch_data_v_o, 0);
      check_eq("wait_busy", dma_busy_o, 1);
      check_eq("wait_drop", prefetch_drop_o, 0);
      step();
    end
    prefetch_dma_req_i = noise;
    mem_resp_v_i       = 1'($urandom_range(0, 1));
    mem_resp_data_i    = $urandom;
    mem_req_ready_i    = 1'($urandom_range(0, 1));
    demand_busy_i      = 1'($urandom_range(0, 1));
    #1;
    check_eq("dlv_datav", dma_prefetch_data_v_o, 1);
    check_eq("dlv_data", dma_prefetch_data_o, d);
    check_eq("dlv_busy", dma_busy_o, 1);
    check_eq("dlv_reqv", mem_req_v_o, 0);
    check_eq("dlv_rready", mem_resp_ready_o, 0);
    last_data = d;
    step();
    dem = 1'($urandom_range(0, 1));
    idle_inputs();
    demand_busy_i   = dem;
    mem_resp_v_i    = 1'($urandom_range(0, 1));
    mem_resp_data_i = $urandom;
    #1;
    check_eq("post_datav", dma_prefetch_data_v_o, 0);
    check_eq("post_hold", dma_prefetch_data_o, last_data);
    check_eq("post_busy", dma_busy_o, dem);
    check_eq("post_reqv", mem_req_v_o, 0);
    step();
    check_eq("no_queue", mem_req_v_o, 0);
    idle_inputs();
  endtask

  initial begin
    last_data           = '0;
    reset_i             = 1'b0;
    prefetch_dma_addr_i = '0;
    mem_resp_data_i     = '0;
    idle_inputs();
    demand_busy_i = 1'b1;
    step();
    step();
    check_eq("rst_busy_dem", dma_busy_o, 1);
    check_eq("rst_reqv", mem_req_v_o, 0);
    check_eq("rst_addr", mem_req_addr_o, 0);
    check_eq("rst_data", dma_prefetch_data_o, 0);
    check_eq("rst_drop", prefetch_drop_o, 0);
    demand_busy_i = 1'b0;
    #1;
    check_eq("rst_busy_nodem", dma_busy_o, 0);
    step();
    reset_i = 1'b1;
    step();

    // Basic prefetch with no stalls.
    run_txn(32'h1040, 32'hDEAD_BEEF, 0, 0, 1'b0);

    // Requests while the miss unit is busy are refused.
    for (int i = 0; i < 3; i++) begin
      demand_busy_i       = 1'b1;
      prefetch_dma_req_i  = 1'b1;
      prefetch_dma_addr_i = 32'h2000;
      #1;
      check_eq("dem_busy", dma_busy_o, 1);
      step();
      check_eq("dem_reqv", mem_req_v_o, 0);
    end
    run_txn(32'h2000, 32'h1234_5678, 1, 2, 1'b0);

    // Ready held low with an extra request arriving meanwhile.
    run_txn(32'h4000, 32'hA5A5_0F0F, 5, 1, 1'b1);

    // Reset while waiting for the response discards the prefetch.
    idle_inputs();
    prefetch_dma_req_i  = 1'b1;
    prefetch_dma_addr_i = 32'h5000;
    step();
    prefetch_dma_req_i = 1'b0;
    mem_req_ready_i    = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    #1;
    check_eq("pre_rst_rready", mem_resp_ready_o, 1);
    reset_i = 1'b0;
    #1;
    check_eq("in_rst_rready", mem_resp_ready_o, 0);
    check_eq("in_rst_busy", dma_busy_o, 0);
    step();
    reset_i         = 1'b1;
    mem_resp_v_i    = 1'b1;
    mem_resp_data_i = 32'hCAFE_F00D;
    #1;
    check_eq("late_rready", mem_resp_ready_o, 0);
    check_eq("late_busy", dma_busy_o, 0);
    step();
    mem_resp_v_i = 1'b0;
    #1;
    check_eq("late_datav", dma_prefetch_data_v_o, 0);
    check_eq("late_data", dma_prefetch_data_o, 0);
    check_eq("late_reqv", mem_req_v_o, 0);
    last_data = '0;

`ifdef PREFETCH_DMA_TIMEOUT_EN
    // No response: drop after timeout_lp waiting cycles.
    prefetch_dma_req_i  = 1'b1;
    prefetch_dma_addr_i = 32'h6000;
    step();
    prefetch_dma_req_i = 1'b0;
    mem_req_ready_i    = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < timeout_lp; i++) begin
      #1;
      check_eq("to_rready", mem_resp_ready_o, 1);
      check_eq("to_nodrop", prefetch_drop_o, 0);
      step();
    end
    check_eq("to_drop", prefetch_drop_o, 1);
    check_eq("to_idle_rready", mem_resp_ready_o, 0);
    check_eq("to_idle_busy", dma_busy_o, 0);
    step();
    check_eq("to_drop_end", prefetch_drop_o, 0);
    check_eq("to_datav", dma_prefetch_data_v_o, 0);
    // Response in the expiry cycle wins.
    run_txn(32'h6040, 32'h0BAD_CAFE, 0, timeout_lp - 1, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      run_txn($urandom, $urandom, int'($urandom_range(0, 6)),
              int'($urandom_range(0, max_pdly_lp)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
